// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with a 2-entry skid buffer,
// synchronous flush and an occupancy output. Handshake outputs are registered.
`default_nettype none

module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding equals the number of words held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_valid) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so any upstream word is simply not taken.
        if (out_ready) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else if (flush) begin
      state     <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
      occupancy <= state_nxt;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_data = main_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized self-checking bench for pipe_stage_reg (WIDTH=8).
`default_nettype none

module tb_pipe_stage_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;

  logic         clock;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
  endtask

  // Compare the four observable outputs against expected values.
  task automatic expect_state(input string name, input logic ev, input logic er,
                              input logic [1:0] eo, input logic [7:0] ed);
    checks++;
    if (out_valid !== ev || in_ready !== er || occupancy !== eo || out_data !== ed) begin
      errors++;
      $display("FAIL %s: got valid=%b ready=%b occ=%0d data=%h, want valid=%b ready=%b occ=%0d data=%h",
               name, out_valid, in_ready, occupancy, out_data, ev, er, eo, ed);
    end
  endtask

  // Load two words (a then b) into an empty stage with out_ready low.
  task automatic fill_two(input logic [7:0] a, input logic [7:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    tick();
    in_data   = b;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    expect_state("power_on_reset", 1'b0, 1'b1, 2'd0, RV);
    reset_n = 1'b1;
    tick();
    expect_state("reset_release", 1'b0, 1'b1, 2'd0, RV);
    fill_two(8'h3C, 8'h4D);
    expect_state("reset_prefill", 1'b1, 1'b0, 2'd2, 8'h3C);
    #2;
    reset_n = 1'b0;
    #1;
    expect_state("async_reset_midstream", 1'b0, 1'b1, 2'd0, RV);
    #3;
    reset_n = 1'b1;
    tick();
    expect_state("after_midstream_reset", 1'b0, 1'b1, 2'd0, RV);
  endtask

  task automatic test_streaming();
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      tick();
      expect_state($sformatf("stream_word%0d", i), 1'b1, 1'b1, 2'd1, words[i]);
    end
    in_valid = 1'b0;
    tick();
    expect_state("stream_drain", 1'b0, 1'b1, 2'd0, 8'h33);
    out_ready = 1'b0;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    tick();
    expect_state("skid_one", 1'b1, 1'b1, 2'd1, 8'hA1);
    in_data = 8'hB2;
    tick();
    expect_state("skid_two", 1'b1, 1'b0, 2'd2, 8'hA1);
    test_backpressure();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_state("skid_pop1", 1'b1, 1'b1, 2'd1, 8'hB2);
    tick();
    expect_state("skid_pop2", 1'b0, 1'b1, 2'd0, 8'hB2);
    out_ready = 1'b0;
  endtask

  // Called with the stage holding A1,B2; changing upstream data must be ignored.
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'hC0 + 8'(i);
      tick();
      expect_state($sformatf("backpressure_cyc%0d", i), 1'b1, 1'b0, 2'd2, 8'hA1);
    end
  endtask

  task automatic test_flush();
    fill_two(8'hC1, 8'hC2);
    expect_state("flush_prefill", 1'b1, 1'b0, 2'd2, 8'hC1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    tick();
    expect_state("flush_result", 1'b0, 1'b1, 2'd0, RV);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    expect_state("flush_settled", 1'b0, 1'b1, 2'd0, RV);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_word;
    logic       rdy_before;
    bit         in_fire;
    bit         out_fire;
    int         bad_order  = 0;
    int         bad_occ    = 0;
    int         bad_ready  = 0;
    int         n_out      = 0;
    for (int c = 0; c < 10000; c++) begin
      rdy_before = in_ready;
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = 8'($urandom);
      out_ready  = 1'($urandom_range(0, 1));
      #1;
      if (in_ready !== rdy_before) bad_ready++;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        n_out++;
        exp_word = (q.size() > 0) ? q.pop_front() : 8'hXX;
        if (out_data !== exp_word) begin
          bad_order++;
          if (bad_order <= 5)
            $display("FAIL random_order: got %h, want %h at cycle %0d", out_data, exp_word, c);
        end
      end
      if (in_fire) q.push_back(in_data);
      tick();
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() < 2)) begin
        bad_occ++;
        if (bad_occ <= 5)
          $display("FAIL random_occupancy: got occ=%0d valid=%b ready=%b, want occ=%0d at cycle %0d",
                   occupancy, out_valid, in_ready, q.size(), c);
      end
    end
    checks++;
    if (bad_order != 0) begin
      errors++;
      $display("FAIL random_order_total: got %0d bad words, want 0", bad_order);
    end
    checks++;
    if (bad_occ != 0) begin
      errors++;
      $display("FAIL random_occupancy_total: got %0d bad cycles, want 0", bad_occ);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL random_ready_comb: got %0d in_ready changes, want 0", bad_ready);
    end
    checks++;
    if (n_out < 1000) begin
      errors++;
      $display("FAIL random_throughput: got %0d transfers out, want >= 1000", n_out);
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
